// File: rtl/serial_pkg.sv
// Shared definitions for the serial UART transmitter: FSM state encoding
// and frame geometry.
package serial_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_START = S_START,
      ST_DATA  = S_DATA,
      ST_STOP  = S_STOP
   } tx_state_e;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO with registered occupancy; head word is always visible on dout.
// Pushes while full and pops while empty are ignored.
module serial_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (reset && do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/serial_uart_tx.sv
// UART transmitter (8N1, LSB first) draining a byte FIFO written by the processor.
//
// state | meaning
// IDLE  | line high; pops the head byte when the FIFO is non-empty
// START | start bit, line low for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high for one bit time
module serial_uart_tx
   import serial_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] serial_in,
   input  logic                      serial_wren_in,
   output logic                      serial_ready_out,
   output logic                      tx_out,
   output logic                      busy_out,
   output logic [$clog2(DEPTH):0]    count_out
);

   localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

   tx_state_e                  state_q, state_d;
   logic [15:0]                baud_q, baud_d;
   logic [2:0]                 bit_q, bit_d;
   logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
   logic                       tx_q, tx_d;
   logic                       busy_q, busy_d;

   logic                       fifo_push, fifo_pop;
   logic                       fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0]  fifo_dout;
   logic                       baud_tc;

   assign serial_ready_out = !fifo_full;
   assign fifo_push        = serial_wren_in && serial_ready_out;
   assign tx_out           = tx_q;
   assign busy_out         = busy_q;
   assign baud_tc          = (baud_q == 16'd0);

   serial_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (int'(DEPTH))
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (serial_in),
      .dout  (fifo_dout),
      .count (count_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Line level is registered from the current state, so the line trails the
   // FSM by one clock; busy is registered the same way to stay aligned with it.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tx_d     = 1'b1;
      busy_d   = (state_q != ST_IDLE) || !fifo_empty;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               baud_d   = BAUD_LOAD;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (baud_tc) begin
               baud_d  = BAUD_LOAD;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         ST_DATA: begin
            tx_d = shift_q[bit_q];
            if (baud_tc) begin
               baud_d = BAUD_LOAD;
               if (bit_q == LAST_BIT) state_d = ST_STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_tc) state_d = ST_IDLE;
            else         baud_d  = baud_q - 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_serial_uart_tx.sv
// Bench for serial_uart_tx: queue-based line model checked every cycle, a UART
// receiver decoding the line, and directed scenarios with literal expectations.
module tb_serial_uart_tx;

   localparam int C     = 4;
   localparam int D     = 4;
   localparam int FRAME = 10 * C;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] serial_in = 8'h00;
   logic       serial_wren_in = 1'b0;
   logic       serial_ready_out, tx_out, busy_out;
   logic [2:0] count_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   serial_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
      .clock            (clock),
      .reset            (reset),
      .serial_in        (serial_in),
      .serial_wren_in   (serial_wren_in),
      .serial_ready_out (serial_ready_out),
      .tx_out           (tx_out),
      .busy_out         (busy_out),
      .count_out        (count_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Line model: a byte queue plus the number of edges since the last byte
   // left the queue. Edge k (1..40) after a pop shows frame bit (k-1)/C;
   // a new byte may leave once 40 edges of the previous frame have passed.
   logic [7:0] mq[$];
   logic [7:0] cur = 8'h00;
   int         k = 1000;
   logic       m_tx = 1'b1, m_busy = 1'b0;
   bit         m_valid = 1'b0;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   always @(posedge clock) begin
      int  pre_cnt;
      bit  do_pop;
      pre_cnt = mq.size();
      if (!reset) begin
         mq.delete();
         k       = 1000;
         m_tx    = 1'b1;
         m_busy  = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_busy = (k < FRAME) || (pre_cnt != 0);
         do_pop = (k >= FRAME) && (pre_cnt != 0);
         if (do_pop) begin
            cur = mq.pop_front();
            k   = 0;
         end else if (k < 1000) begin
            k++;
         end
         if (serial_wren_in && pre_cnt != D) mq.push_back(serial_in);
         m_tx = (k >= 1 && k <= FRAME) ? frame_bit(cur, (k - 1) / C) : 1'b1;
      end
   end

   always @(negedge clock) begin
      if (m_valid) begin
         check("cyc_tx",    int'(tx_out),           int'(m_tx));
         check("cyc_busy",  int'(busy_out),         int'(m_busy));
         check("cyc_count", int'(count_out),        mq.size());
         check("cyc_ready", int'(serial_ready_out), int'(mq.size() != D));
      end
   end

   // Independent UART receiver sampling mid-bit; frames touched by reset are dropped.
   logic [7:0] rxq[$];
   int         start_cyc[$];

   initial begin : rx_mon
      logic       prev;
      logic [7:0] b;
      bit         ok;
      prev = 1'b1;
      b    = 8'h00;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && prev && tx_out === 1'b0) begin
            start_cyc.push_back(cyc);
            ok = 1'b1;
            repeat (C/2) @(negedge clock);
            if (!reset) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clock);
               if (!reset) ok = 1'b0;
               b[i] = tx_out;
            end
            repeat (C) @(negedge clock);
            if (!reset) ok = 1'b0;
            if (ok) begin
               check("rx_stop_bit", int'(tx_out), 1);
               rxq.push_back(b);
            end
         end
         prev = tx_out;
      end
   end

   task automatic push(input logic [7:0] b);
      serial_in      = b;
      serial_wren_in = 1'b1;
      @(posedge clock); #1;
      serial_wren_in = 1'b0;
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp[$]);
      check({name, "_len"}, rxq.size(), exp.size());
      for (int i = 0; i < exp.size() && i < rxq.size(); i++)
         check({name, "_byte"}, int'(rxq[i]), int'(exp[i]));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [9:0] pat;
      logic [7:0] exp[$];
      int         guard;

      // Reset state
      repeat (3) @(posedge clock); #1;
      check("rst_tx",    int'(tx_out), 1);
      check("rst_busy",  int'(busy_out), 0);
      check("rst_count", int'(count_out), 0);
      check("rst_ready", int'(serial_ready_out), 1);
      reset = 1'b1;
      repeat (3) @(posedge clock); #1;

      // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 starting 2 clocks after push
      pat = 10'b11_0100_1010;
      push(8'hA5);
      @(negedge clock);
      check("a5_idle_after_push", int'(tx_out), 1);
      @(negedge clock);
      check("a5_idle_pop_edge", int'(tx_out), 1);
      @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         check("a5_bit", int'(tx_out), int'(pat[i]));
         if (i == 9) check("a5_busy_in_stop", int'(busy_out), 1);
         repeat (C) @(negedge clock);
      end
      check("a5_busy_after_stop", int'(busy_out), 0);
      check("a5_tx_after_stop", int'(tx_out), 1);
      exp = '{8'hA5};
      check_rx("a5_rx", exp);

      // Fill and overflow: 0x06 is dropped
      rxq.delete();
      @(posedge clock); #1;
      for (int i = 1; i <= 6; i++) push(8'(i));
      @(negedge clock);
      check("ovf_count_full", int'(count_out), 4);
      check("ovf_ready_low", int'(serial_ready_out), 0);
      repeat (5 * (FRAME + 1) + 15) @(negedge clock);
      exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_rx("ovf_rx", exp);
      check("ovf_drained", int'(count_out), 0);

      // Pointer wrap: 12 bytes, writing only when ready
      rxq.delete();
      @(posedge clock); #1;
      guard = 0;
      for (int i = 0; i < 12 && guard < 2000; ) begin
         if (serial_ready_out) begin
            push(8'(8'h10 + i));
            i++;
         end else begin
            @(posedge clock); #1;
            guard++;
         end
      end
      check("wrap_no_timeout", int'(guard < 2000), 1);
      repeat (6 * (FRAME + 1) + 15) @(negedge clock);
      exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
              8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
      check_rx("wrap_rx", exp);

      // Back-to-back: second start bit 41 cycles after the first
      rxq.delete();
      start_cyc.delete();
      @(posedge clock); #1;
      push(8'h3C);
      push(8'hC3);
      repeat (2 * (FRAME + 1) + 15) @(negedge clock);
      check("b2b_starts", start_cyc.size(), 2);
      if (start_cyc.size() == 2)
         check("b2b_gap", start_cyc[1] - start_cyc[0], 41);
      exp = '{8'h3C, 8'hC3};
      check_rx("b2b_rx", exp);

      // Reset during data bit 3 of 0xFF with two bytes queued
      rxq.delete();
      @(posedge clock); #1;
      push(8'hFF);
      push(8'h5A);
      push(8'h66);
      repeat (16) @(posedge clock); #1;
      check("rstmid_queued", int'(count_out), 2);
      reset          = 1'b0;
      serial_in      = 8'h77;
      serial_wren_in = 1'b1;
      @(posedge clock); #1;
      check("rstmid_tx", int'(tx_out), 1);
      check("rstmid_count", int'(count_out), 0);
      repeat (5) @(posedge clock); #1;
      check("rstmid_write_ignored", int'(count_out), 0);
      start_cyc.delete();
      reset          = 1'b1;
      serial_wren_in = 1'b0;
      repeat (FRAME + 20) @(negedge clock);
      check("rstmid_no_frame", start_cyc.size(), 0);
      check("rstmid_no_rx", rxq.size(), 0);
      check("rstmid_idle_tx", int'(tx_out), 1);

      // Simultaneous push and pop at count 2
      rxq.delete();
      @(posedge clock); #1;
      push(8'hB1);
      push(8'hB2);
      push(8'hB3);
      repeat (39) @(posedge clock); #1;
      check("sim_pre_count", int'(count_out), 2);
      push(8'hB4);
      check("sim_post_count", int'(count_out), 2);
      repeat (4 * (FRAME + 1) + 15) @(negedge clock);
      exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
      check_rx("sim_rx", exp);
      check("sim_idle_busy", int'(busy_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
